// File: rtl/blake2_digest_reader.sv
// Captures each new Blake2 digest and streams it out as proc_bus_width words
// over a valid/ready handshake, with truncation and a sticky overrun flag.
module blake2_digest_reader #(
  parameter int proc_bus_width = 32,
  parameter int digest_bytes   = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [511:0]              digest,
  input  logic                      digest_valid,
  input  logic                      flush,
  output logic [proc_bus_width-1:0] data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      last_out,
  output logic                      busy,
  output logic                      overrun
);

  localparam int NWORDS = (digest_bytes * 8 + proc_bus_width - 1) / proc_bus_width;
  localparam int CW     = $clog2(NWORDS + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic            dv_q;
  logic [511:0]    hold;
  logic [511:0]    byte_mask;
  logic [CW-1:0]   cnt;
  logic            capture, xfer, at_last, last_xfer, load, drop;

  // Bytes past digest_bytes are zeroed once at load so they shift out as padding.
  for (genvar b = 0; b < 64; b++) begin : g_mask
    assign byte_mask[511-8*b -: 8] = (b < digest_bytes) ? 8'hff : 8'h00;
  end

  assign capture   = digest_valid & ~dv_q;
  assign xfer      = (state == SEND) & ready_in;
  assign at_last   = (cnt == CW'(NWORDS - 1));
  assign last_xfer = xfer & at_last;
  assign load      = capture & ~flush & ((state == IDLE) | last_xfer);
  assign drop      = capture & ~flush & (state == SEND) & ~last_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (capture) state_nxt = SEND;
        SEND:    if (last_xfer && !capture) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_out = (state == SEND);
    busy      = valid_out;
    last_out  = valid_out & at_last;
    data_out  = '0;
    if (valid_out) data_out = hold[511 -: proc_bus_width];
  end

  // dv_q resets high so a digest already valid at reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q    <= 1'b1;
      hold    <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      dv_q <= digest_valid;
      if (flush) begin
        cnt     <= '0;
        overrun <= 1'b0;
      end else begin
        if (drop) overrun <= 1'b1;
        if (load) begin
          hold <= digest & byte_mask;
          cnt  <= '0;
        end else if (xfer) begin
          hold <= {hold[511-proc_bus_width:0], {proc_bus_width{1'b0}}};
          cnt  <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_blake2_digest_reader.sv
// Directed + randomized bench: three reader configurations share one input
// stream; expected words are built directly from the digest byte array.
module tb_blake2_digest_reader;

  logic         clk = 1'b0;
  logic         reset_n, digest_valid, flush, ready_in;
  logic [511:0] digest;
  logic [31:0]  d_a, d_t, d_s;
  logic         v_a, v_t, v_s, l_a, l_t, l_s, b_a, b_t, b_s, o_a, o_t, o_s;
  int           sel;
  logic [31:0]  obs_data;
  logic         obs_valid, obs_last, obs_busy, obs_ovr;
  int           checks = 0, errors = 0;
  byte unsigned cur[64], nxt[64];

  always #5 clk = ~clk;

  blake2_digest_reader #(.proc_bus_width(32), .digest_bytes(64)) dut (
    .clk(clk), .reset_n(reset_n), .digest(digest), .digest_valid(digest_valid),
    .flush(flush), .data_out(d_a), .valid_out(v_a), .ready_in(ready_in),
    .last_out(l_a), .busy(b_a), .overrun(o_a));
  blake2_digest_reader #(.proc_bus_width(32), .digest_bytes(30)) dut_t (
    .clk(clk), .reset_n(reset_n), .digest(digest), .digest_valid(digest_valid),
    .flush(flush), .data_out(d_t), .valid_out(v_t), .ready_in(ready_in),
    .last_out(l_t), .busy(b_t), .overrun(o_t));
  blake2_digest_reader #(.proc_bus_width(32), .digest_bytes(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .digest(digest), .digest_valid(digest_valid),
    .flush(flush), .data_out(d_s), .valid_out(v_s), .ready_in(ready_in),
    .last_out(l_s), .busy(b_s), .overrun(o_s));

  always_comb begin
    case (sel)
      1:       {obs_data, obs_valid, obs_last, obs_busy, obs_ovr} = {d_t, v_t, l_t, b_t, o_t};
      2:       {obs_data, obs_valid, obs_last, obs_busy, obs_ovr} = {d_s, v_s, l_s, b_s, o_s};
      default: {obs_data, obs_valid, obs_last, obs_busy, obs_ovr} = {d_a, v_a, l_a, b_a, o_a};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack(input byte unsigned a[64]);
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[511-8*i -: 8] = a[i];
    return v;
  endfunction

  // Word k = digest bytes 4k..4k+3, MSB first, zero beyond the truncation length.
  function automatic logic [31:0] exp_word(input int k, input int nbytes);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) begin
      int idx = 4 * k + j;
      w = {w[23:0], (idx < nbytes) ? cur[idx] : 8'h00};
    end
    return w;
  endfunction

  task automatic rand_bytes(output byte unsigned a[64]);
    for (int i = 0; i < 64; i++) a[i] = 8'($urandom);
  endtask

  task automatic start_digest();
    @(negedge clk);
    digest_valid = 1'b0;
    @(negedge clk);
    digest = pack(cur);
    digest_valid = 1'b1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready
  task automatic readout(input int nbytes, input int limit, input int mode,
                         input int ovr_at, input bit b2b);
    int nw = (nbytes + 3) / 4;
    int lim = (limit < 0) ? nw : limit;
    int k = 0, cyc = 0;
    bit ovr_done = 1'b0, r;
    while (k < lim) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        checks++; errors++;
        $error("FAIL readout_timeout observed word %0d expected word %0d", k, lim);
        break;
      end
      if (cyc == 1) digest_valid = 1'b0;
      chk("valid", 32'(obs_valid), 32'd1);
      chk("busy", 32'(obs_busy), 32'd1);
      chk($sformatf("data_w%0d", k), obs_data, exp_word(k, nbytes));
      chk($sformatf("last_w%0d", k), 32'(obs_last), 32'(k == nw - 1));
      if (k == ovr_at && !ovr_done) begin
        digest = {16{$urandom}};
        digest_valid = 1'b1;
        ovr_done = 1'b1;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready_in = r;
      if (r) begin
        if (b2b && k == nw - 1) begin
          digest = pack(nxt);
          digest_valid = 1'b1;
        end
        k++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; digest_valid = 1'b0; flush = 1'b0; ready_in = 1'b0;
    digest = '0; sel = 0;
    for (int i = 0; i < 64; i++) cur[i] = 8'(i);
    #12;
    chk("rst_data", obs_data, 32'h0);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_last", 32'(obs_last), 32'd0);
    chk("rst_ovr", 32'(obs_ovr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // basic readout
    start_digest();
    readout(64, -1, 0, -1, 1'b0);
    @(negedge clk);
    chk("basic_after_valid", 32'(obs_valid), 32'd0);
    chk("basic_after_last", 32'(obs_last), 32'd0);

    // backpressure
    start_digest();
    readout(64, -1, 1, -1, 1'b0);
    @(negedge clk);
    chk("bp_after_valid", 32'(obs_valid), 32'd0);

    // truncation to 30 bytes
    do_flush();
    sel = 1;
    start_digest();
    readout(30, -1, 0, -1, 1'b0);
    @(negedge clk);
    chk("trunc_after_valid", 32'(obs_valid), 32'd0);

    // single-word readout
    do_flush();
    sel = 2;
    rand_bytes(cur);
    start_digest();
    readout(4, -1, 2, -1, 1'b0);
    @(negedge clk);
    chk("single_after_valid", 32'(obs_valid), 32'd0);
    sel = 0;

    // overrun during word 5
    do_flush();
    rand_bytes(cur);
    start_digest();
    readout(64, -1, 2, 5, 1'b0);
    @(negedge clk);
    chk("ovr_set", 32'(obs_ovr), 32'd1);
    start_digest();
    @(negedge clk);
    chk("ovr_sticky_valid", 32'(obs_valid), 32'd1);
    chk("ovr_sticky", 32'(obs_ovr), 32'd1);
    do_flush();
    chk("ovr_flush", 32'(obs_ovr), 32'd0);
    chk("ovr_flush_valid", 32'(obs_valid), 32'd0);

    // back-to-back
    rand_bytes(cur);
    rand_bytes(nxt);
    start_digest();
    readout(64, -1, 2, -1, 1'b1);
    cur = nxt;
    readout(64, -1, 2, -1, 1'b0);
    @(negedge clk);
    chk("b2b_after_valid", 32'(obs_valid), 32'd0);
    chk("b2b_ovr", 32'(obs_ovr), 32'd0);

    // reset at word 3, digest_valid held high through release
    rand_bytes(cur);
    start_digest();
    readout(64, 3, 0, -1, 1'b0);
    @(negedge clk);
    chk("rst_w3_data", obs_data, exp_word(3, 64));
    #2 reset_n = 1'b0;
    digest_valid = 1'b1;
    #1;
    chk("rst_mid_data", obs_data, 32'h0);
    chk("rst_mid_valid", 32'(obs_valid), 32'd0);
    chk("rst_mid_last", 32'(obs_last), 32'd0);
    chk("rst_mid_busy", 32'(obs_busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dv_high_release", 32'(obs_valid), 32'd0);
    end

    // flush at word 7
    rand_bytes(cur);
    start_digest();
    readout(64, 7, 2, -1, 1'b0);
    @(negedge clk);
    chk("flush_w7_data", obs_data, exp_word(7, 64));
    flush = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", 32'(obs_valid), 32'd0);
    chk("flush_last", 32'(obs_last), 32'd0);
    chk("flush_ovr", 32'(obs_ovr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_digest_reader.md
Name: blake2_digest_reader

Overview:
- Downstream of the Blake2 core; consumes its 512-bit digest and digest_valid.
- Captures each new digest into a holding register.
- Returns the digest to the processor as a stream of bus-width words using a valid/ready handshake.
- Supports truncated digest lengths and flags digests that arrive while a readout is still in progress.

Parameters:
- proc_bus_width, 32, output word width in bits; must divide 512 (8, 16, 32, 64, 128).
- digest_bytes, 64, digest length returned in bytes, 1..64.
- NWORDS (local), ceil(digest_bytes*8/proc_bus_width), number of words per readout.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- digest, input, 512, Blake2 digest; byte 0 in bits [511:504].
- digest_valid, input, 1, level from the core; high while the digest is valid.
- flush, input, 1, synchronous abort; clears state and overrun.
- data_out, output, proc_bus_width, current digest word.
- valid_out, output, 1, data_out is valid.
- ready_in, input, 1, processor accepts data_out.
- last_out, output, 1, current word is the final word of the digest.
- busy, output, 1, a readout is in progress; equals valid_out.
- overrun, output, 1, sticky: a digest was dropped.

Behaviour:
- Clock/reset: clk, with asynchronous active-low reset_n.
- Reset values:
  - data_out = 0, valid_out = 0, last_out = 0, busy = 0, overrun = 0.
  - State = IDLE, word counter = 0.
  - dv_q (registered digest_valid) resets to 1, so a digest already valid at reset release is not emitted.
- Capture event: digest_valid = 1 and dv_q = 0 (rising edge). dv_q <= digest_valid every cycle.
- Holding register: hold[511:0] loads digest; bytes beyond digest_bytes are forced to 0 at load.
- States:
  - IDLE:
    - On a capture event: load hold, counter = 0, go to SEND.
    - valid_out rises on the next cycle, giving a 1-cycle latency from the digest_valid edge to the first word.
  - SEND:
    - valid_out = 1.
    - data_out = hold[511 -: proc_bus_width].
    - last_out = (counter == NWORDS-1).
  - Transfer: valid_out && ready_in in the same cycle.
    - On transfer: hold shifts left by proc_bus_width (zero fill) and counter increments.
    - On transfer of the last word: go to IDLE, so valid_out = 0 on the next cycle.
- Handshake rules:
  - While valid_out = 1 and ready_in = 0, data_out and last_out are held stable.
  - valid_out never drops without a transfer, except on flush or reset.
- Word order:
  - Word 0 carries digest bytes 0.. in MSB-first order.
  - A partial final word carries its valid bytes in the upper bits and zeros below.
- Boundary conditions:
  - Capture event in SEND (not coinciding with the last transfer):
    - The digest is dropped and overrun is set.
    - The readout in progress is unaffected.
  - Capture event in the same cycle as the last-word transfer:
    - The new digest is loaded, counter = 0, state stays SEND.
    - valid_out stays high (back-to-back readouts); no overrun.
  - flush (highest priority after reset):
    - Next cycle: state = IDLE, valid_out = 0, last_out = 0, counter = 0, overrun = 0.
    - A capture event in the same cycle as flush is discarded, but dv_q still updates.
  - overrun: stays 1 until flush or reset; a subsequent successful capture does not clear it.
  - Single-word readout: NWORDS == 1 gives last_out = 1 on the first word.
  - Reset mid-readout: asynchronous return to the reset values; the partial readout is lost.
  - digest_valid held high across several readouts: only one capture per rising edge.
- Counter width: clog2(NWORDS+1) bits; no wrap, because it is reset on every load.

Test Plan:
All scenarios use digest bytes 0x00..0x3f (byte 0 = 0x00 at MSB).
- Basic readout (proc_bus_width = 32, digest_bytes = 64), ready_in held 1, digest_valid pulsed 0->1:
  - 16 consecutive words 0x00010203, 0x04050607, … 0x3c3d3e3f.
  - last_out = 1 only on the 16th word.
  - valid_out is low the cycle after.
- Backpressure: ready_in toggled 1,0,0,1 repeatedly:
  - data_out and last_out stable during the stalls.
  - The word sequence is identical to the basic readout; no words are duplicated or skipped.
- Truncation (digest_bytes = 30, proc_bus_width = 32):
  - 8 words; the 8th word = 0x1c1d0000 with last_out = 1.
- Overrun:
  - Second digest_valid rising edge during word 5, carrying a different digest.
  - The original 16 words still complete, and overrun = 1.
  - After flush, overrun = 0.
- Back-to-back:
  - New digest_valid rising edge in the same cycle the last word transfers.
  - valid_out stays 1 and word 0 of the new digest follows immediately; overrun stays 0.
- Reset and flush:
  - reset_n asserted at word 3: all outputs 0 immediately.
  - digest_valid held high through reset release: no readout starts.
  - flush at word 7: valid_out = 0 on the next cycle.
